// File: rtl/maxnet_iter_ctrl.sv
// Maxnet sequencer: stream-loads N_NEURONS activations, loops MUL/SUM1/SUM2/ACT/CHECK until one survivor or MAX_ITER.
// Latency: N loads + 5 cycles per iteration + 1 to res_valid; in_valid low stalls LOAD, res_ready low holds RESULT.
module maxnet_iter_ctrl #(
  parameter int N_NEURONS = 4,
  parameter int MAX_ITER  = 32,
  parameter int ITER_W    = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic [N_NEURONS-1:0] o_ld_sel,
  output logic                 o_in_mux_sel,
  output logic                 o_mul_en,
  output logic                 o_sum_en,
  output logic                 o_act_en,
  input  logic                 i_flag,
  output logic                 o_busy,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic                 o_timeout,
  output logic [ITER_W-1:0]    o_iter_cnt
);

  localparam int LD_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_MUL    = 3'd2,
    S_SUM1   = 3'd3,
    S_SUM2   = 3'd4,
    S_ACT    = 3'd5,
    S_CHECK  = 3'd6,
    S_RESULT = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LD_W-1:0]     r_load_cnt;
  logic [ITER_W-1:0]   r_iter_cnt;
  logic                r_timeout;

  logic                w_in_ready;
  logic [N_NEURONS-1:0] w_ld_sel;
  logic                w_in_mux_sel;
  logic                w_mul_en;
  logic                w_sum_en;
  logic                w_act_en;
  logic                w_busy;
  logic                w_res_valid;

  logic                w_load_last;
  logic                w_iter_cap;

  assign w_load_last = (r_load_cnt == LD_W'(N_NEURONS - 1));
  assign w_iter_cap  = (r_iter_cnt == ITER_W'(MAX_ITER));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_in_ready   = 1'b0;
    w_ld_sel     = '0;
    w_in_mux_sel = 1'b0;
    w_mul_en     = 1'b0;
    w_sum_en     = 1'b0;
    w_act_en     = 1'b0;
    w_busy       = 1'b1;
    w_res_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (i_start) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_in_ready   = 1'b1;
        w_in_mux_sel = 1'b1;
        // Load enable is Mealy on in_valid so a stalled cycle writes nothing.
        if (i_in_valid) begin
          w_ld_sel = N_NEURONS'(1) << r_load_cnt;
          if (w_load_last) begin
            w_state_nxt = S_MUL;
          end
        end
      end
      S_MUL: begin
        w_mul_en    = 1'b1;
        w_state_nxt = S_SUM1;
      end
      S_SUM1: begin
        w_sum_en    = 1'b1;
        w_state_nxt = S_SUM2;
      end
      S_SUM2: begin
        w_sum_en    = 1'b1;
        w_state_nxt = S_ACT;
      end
      S_ACT: begin
        w_act_en    = 1'b1;
        w_ld_sel    = '1;
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        // iter_cnt already counts the iteration that just finished.
        if (!i_flag || w_iter_cap) begin
          w_state_nxt = S_RESULT;
        end else begin
          w_state_nxt = S_MUL;
        end
      end
      S_RESULT: begin
        w_res_valid = 1'b1;
        if (i_res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_load_cnt <= '0;
      r_iter_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_load_cnt <= '0;
            r_iter_cnt <= '0;
            r_timeout  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (i_in_valid) begin
            r_load_cnt <= w_load_last ? '0 : r_load_cnt + LD_W'(1);
          end
        end
        S_ACT: begin
          r_iter_cnt <= r_iter_cnt + ITER_W'(1);
        end
        S_CHECK: begin
          if (i_flag && w_iter_cap) begin
            r_timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_ld_sel     = w_ld_sel;
  assign o_in_mux_sel = w_in_mux_sel;
  assign o_mul_en     = w_mul_en;
  assign o_sum_en     = w_sum_en;
  assign o_act_en     = w_act_en;
  assign o_busy       = w_busy;
  assign o_res_valid  = w_res_valid;
  assign o_timeout    = r_timeout;
  assign o_iter_cnt   = r_iter_cnt;

endmodule

// File: tb/tb_maxnet_iter_ctrl.sv
// Directed bench for maxnet_iter_ctrl: inputs driven and outputs sampled just after each falling edge.
module tb_maxnet_iter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] ld_sel;
  logic       in_mux_sel;
  logic       mul_en;
  logic       sum_en;
  logic       act_en;
  logic       flag;
  logic       busy;
  logic       res_valid;
  logic       res_ready;
  logic       timeout;
  logic [5:0] iter_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  maxnet_iter_ctrl #(.N_NEURONS(4), .MAX_ITER(32), .ITER_W(6)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .o_ld_sel     (ld_sel),
    .o_in_mux_sel (in_mux_sel),
    .o_mul_en     (mul_en),
    .o_sum_en     (sum_en),
    .o_act_en     (act_en),
    .i_flag       (flag),
    .o_busy       (busy),
    .o_res_valid  (res_valid),
    .i_res_ready  (res_ready),
    .o_timeout    (timeout),
    .o_iter_cnt   (iter_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_strobes"}, 32'({in_ready, ld_sel, in_mux_sel, mul_en, sum_en, act_en, res_valid}), 0);
    chk({tag, "_iter"}, 32'(iter_cnt), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n_mul, n_act, n_sum, cyc, rv, loads;
    logic done;
    logic pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; flag = 1'b0; res_ready = 1'b0;
    tick(); tick(); #1;
    chk_quiet("por");
    tick(); rst = 1'b0;

    // Back-to-back load
    tick(); start = 1'b1; in_valid = 1'b1; #1;
    chk("idle_busy", 32'(busy), 0);
    for (int k = 0; k < 4; k++) begin
      tick(); start = 1'b0; #1;
      chk("b2b_ld_sel", 32'(ld_sel), 32'(1 << k));
      chk("b2b_in_ready", 32'(in_ready), 1);
      chk("b2b_mux", 32'(in_mux_sel), 1);
    end
    tick(); in_valid = 1'b0; #1;
    chk("b2b_mul_en", 32'(mul_en), 1);
    chk("b2b_mul_ld", 32'(ld_sel), 0);

    // Convergence: flag high for two CHECKs, then low
    n_mul = 1; n_act = 0; n_sum = 0; cyc = 0; done = 1'b0;
    for (int c = 2; c <= 60 && !done; c++) begin
      tick(); flag = (n_act < 3); #1;
      if (act_en) begin
        n_act++;
        chk("conv_act_ld", 32'(ld_sel), 32'hF);
        chk("conv_act_mux", 32'(in_mux_sel), 0);
      end
      if (mul_en) n_mul++;
      if (sum_en) n_sum++;
      if (res_valid) begin
        done = 1'b1;
        cyc = c;
      end
    end
    chk("conv_done", 32'(done), 1);
    chk("conv_cycles", 32'(cyc), 16);
    chk("conv_iter", 32'(iter_cnt), 3);
    chk("conv_timeout", 32'(timeout), 0);
    chk("conv_n_act", 32'(n_act), 3);
    chk("conv_n_mul", 32'(n_mul), 3);
    chk("conv_n_sum", 32'(n_sum), 6);

    // Result backpressure with start pulsed during RESULT
    rv = 1;
    for (int k = 2; k <= 6; k++) begin
      tick(); start = 1'b1; res_ready = (k == 6); #1;
      if (res_valid) rv++;
    end
    tick(); start = 1'b0; res_ready = 1'b0; #1;
    chk("bp_rv_cycles", 32'(rv), 6);
    chk("bp_busy", 32'(busy), 0);
    chk("bp_res_valid", 32'(res_valid), 0);
    chk("bp_iter_hold", 32'(iter_cnt), 3);
    chk("bp_timeout_hold", 32'(timeout), 0);

    // Stalled load
    tick(); start = 1'b1; in_valid = 1'b0; #1;
    loads = 0;
    for (int k = 0; k < 7; k++) begin
      tick(); start = 1'b0; in_valid = pat[k]; #1;
      chk("stall_in_ready", 32'(in_ready), 1);
      chk("stall_ld_sel", 32'(ld_sel), pat[k] ? 32'(1 << loads) : 32'd0);
      if (k == 0) chk("stall_iter_clr", 32'(iter_cnt), 0);
      if (pat[k]) loads++;
    end
    tick(); in_valid = 1'b0; flag = 1'b1; res_ready = 1'b1; #1;
    chk("stall_mul_en", 32'(mul_en), 1);

    // Timeout with flag held high
    n_mul = 1; done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      tick(); #1;
      if (mul_en) n_mul++;
      if (res_valid) done = 1'b1;
    end
    chk("to_done", 32'(done), 1);
    chk("to_timeout", 32'(timeout), 1);
    chk("to_iter", 32'(iter_cnt), 32);
    chk("to_n_mul", 32'(n_mul), 32);
    tick(); res_ready = 1'b0; flag = 1'b0; #1;
    chk("to_one_cycle_busy", 32'(busy), 0);
    chk("to_idle_rv", 32'(res_valid), 0);
    chk("to_iter_hold", 32'(iter_cnt), 32);
    chk("to_timeout_hold", 32'(timeout), 1);

    // Reset in the middle of LOAD
    tick(); start = 1'b1; in_valid = 1'b0; #1;
    tick(); start = 1'b0; in_valid = 1'b1; #1;
    chk("mid_ld0", 32'(ld_sel), 32'h1);
    tick(); #1;
    chk("mid_ld1", 32'(ld_sel), 32'h2);
    tick(); #1;
    rst = 1'b1; #1;
    chk_quiet("mid_rst");
    tick(); rst = 1'b0; start = 1'b1; in_valid = 1'b1; #1;
    tick(); start = 1'b0; #1;
    chk("mid_reload_ld", 32'(ld_sel), 32'h1);
    tick(); in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
